// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared state encoding and default width for the serial adder
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - gate-level 1-bit full adder built from two half adders and an or gate
// Ports: a, b (addend bits), c (carry in) -> s (sum bit), co (carry out)
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    halfadder u_ha1 (
        .a (s0),
        .b (c),
        .s (s),
        .c (c1)
    );

    or g_or (co, c0, c1);

endmodule

// File: rtl/halfadder.sv
// rtl/halfadder.sv - gate-level half adder cell
// Ports: a, b (addends) -> s (sum), c (carry)
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    xor g_xor (s, a, b);
    and g_and (c, a, b);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder controller sharing one full adder cell
// Ports: clk, rst_n (sync active-low), start, abort, a, b, cin (sampled on accept)
//        -> busy (in RUN), done (one-cycle result pulse), sum, cout (result registers)
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] shreg_a;
    logic [WIDTH-1:0] shreg_b;
    logic [WIDTH-1:0] shreg_s;
    logic [WIDTH-1:0] shreg_s_next;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic cell_s;
    logic cell_co;
    logic load;
    logic step;
    logic finish;

    full_adder_cell u_cell (
        .a  (shreg_a[0]),
        .b  (shreg_b[0]),
        .c  (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == LAST) begin
                        finish  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // start here chains straight into the next operation
                if (start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    // Result bits enter at the MSB so after WIDTH steps the LSB-first stream is aligned
    always_comb begin
        shreg_s_next            = shreg_s >> 1;
        shreg_s_next[WIDTH-1]   = cell_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_a <= '0;
            shreg_b <= '0;
            shreg_s <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                shreg_a <= a;
                shreg_b <= b;
                shreg_s <= '0;
                carry_q <= cin;
                cnt_q   <= '0;
            end else if (step) begin
                shreg_a <= shreg_a >> 1;
                shreg_b <= shreg_b >> 1;
                shreg_s <= shreg_s_next;
                carry_q <= cell_co;
                cnt_q   <= cnt_q + CW'(1);
            end
            if (finish) begin
                sum  <= shreg_s_next;
                cout <= cell_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1)
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       w1_start;
    logic       w1_abort;
    logic [0:0] w1_a;
    logic [0:0] w1_b;
    logic       w1_cin;
    logic       w1_busy;
    logic       w1_done;
    logic [0:0] w1_sum;
    logic       w1_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w1_start),
        .abort (w1_abort),
        .a     (w1_a),
        .b     (w1_b),
        .cin   (w1_cin),
        .busy  (w1_busy),
        .done  (w1_done),
        .sum   (w1_sum),
        .cout  (w1_cout)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents operands with start for one edge; returns at the negedge after acceptance
    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done (bounded); nb counts cycles seen with busy high
    task automatic wait_done(output int lat, output int nb);
        lat = 0;
        nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL wait_done: timeout after %0d cycles, expected done", lat);
        end
    endtask

    initial begin
        int lat;
        int nb;
        int ndone;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'h01, 8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[4] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'hC3, 8'h81, 1'b0, 8'h44, 1'b1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; cin = 1'b0;
        w1_start = 1'b0; w1_abort = 1'b0; w1_a = '0; w1_b = '0; w1_cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_sum", 32'(sum), 32'h00);
        check("reset_cout", 32'(cout), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(lat, nb);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'd8);
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'h0);
        end

        // start during RUN is ignored
        launch(8'h3C, 8'h0F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, nb);
        check("ignore_start_latency", 32'(lat + 3), 32'd8);
        check("ignore_start_sum", 32'(sum), 32'h4B);
        check("ignore_start_cout", 32'(cout), 32'h0);

        // back-to-back: start held in DONE (abort also high, start wins)
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("b2b_no_gap_busy", 32'(busy), 32'h1);
        check("b2b_sum_held", 32'(sum), 32'h4B);
        wait_done(lat, nb);
        check("b2b_second_done_gap", 32'(lat + 1), 32'd9);
        check("b2b_sum", 32'(sum), 32'h30);
        check("b2b_cout", 32'(cout), 32'h0);

        // abort at RUN cycle 4 after a 0x4B result
        launch(8'h3C, 8'h0F, 1'b0);
        wait_done(lat, nb);
        check("pre_abort_sum", 32'(sum), 32'h4B);
        launch(8'h80, 8'h80, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_sum", 32'(sum), 32'h4B);
        check("abort_cout", 32'(cout), 32'h0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        // synchronous reset mid-RUN
        launch(8'h3C, 8'h0F, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_sum", 32'(sum), 32'h00);
        check("midrst_cout", 32'(cout), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("midrst_stays_idle", 32'(ndone), 32'd0);
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(lat, nb);
        check("postrst_latency", 32'(lat), 32'd8);
        check("postrst_sum", 32'(sum), 32'h80);
        check("postrst_cout", 32'(cout), 32'h0);

        // WIDTH=1 instance
        check("w1_reset_sum", 32'(w1_sum), 32'h0);
        @(negedge clk);
        w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_start = 1'b1;
        @(negedge clk);
        w1_start = 1'b0;
        check("w1_busy", 32'(w1_busy), 32'h1);
        check("w1_done_early", 32'(w1_done), 32'h0);
        @(negedge clk);
        check("w1_done", 32'(w1_done), 32'h1);
        check("w1_busy_after", 32'(w1_busy), 32'h0);
        check("w1_sum", 32'(w1_sum), 32'h1);
        check("w1_cout", 32'(w1_cout), 32'h1);
        w1_a = 1'b1; w1_b = 1'b0; w1_cin = 1'b0; w1_start = 1'b1;
        @(negedge clk);
        w1_start = 1'b0;
        @(negedge clk);
        check("w1_b2b_done", 32'(w1_done), 32'h1);
        check("w1_b2b_sum", 32'(w1_sum), 32'h1);
        check("w1_b2b_cout", 32'(w1_cout), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
